// File: rtl/sw_cond_pkg.sv
// Shared types and default parameters for the switch conditioner.
// Optional edge pulses are controlled by SW_COND_EDGE_EN in the users of this package.
package sw_cond_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

    localparam int SW_COND_DEF_WIDTH    = 5;
    localparam int SW_COND_DEF_SYNC     = 2;
    localparam int SW_COND_DEF_DEBOUNCE = 500000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser, stability counter and STABLE/COUNTING FSM.
// SW_COND_EDGE_EN adds registered rise/fall pulses.
//
// state       | meaning
// ST_STABLE   | synchronised input matches the accepted level
// ST_COUNTING | input differs; counting consecutive cycles of the new level
module sw_debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_COND_DEF_SYNC,
    parameter int DEBOUNCE_CYCLES = SW_COND_DEF_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic toggle
`ifdef SW_COND_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CW-1:0]          count;
    deb_state_t             state;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Toggle is combinational so the top can set change_pending on the same edge.
    always_comb begin
        toggle = 1'b0;
        if (sync_bit != stable) begin
            if (state == ST_STABLE) begin
                toggle = (DEBOUNCE_CYCLES == 1);
            end else begin
                toggle = (count == TERMINAL);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_STABLE;
            count  <= '0;
            stable <= 1'b0;
`ifdef SW_COND_EDGE_EN
            rise   <= 1'b0;
            fall   <= 1'b0;
`endif
        end else begin
`ifdef SW_COND_EDGE_EN
            rise <= toggle & ~stable;
            fall <= toggle & stable;
`endif
            if (toggle) begin
                stable <= ~stable;
            end
            case (state)
                ST_STABLE: begin
                    if (sync_bit != stable && !toggle) begin
                        count <= CW'(1);
                        state <= ST_COUNTING;
                    end else begin
                        count <= '0;
                    end
                end
                ST_COUNTING: begin
                    if (sync_bit == stable || toggle) begin
                        count <= '0;
                        state <= ST_STABLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    count <= '0;
                    state <= ST_STABLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces WIDTH slide switches and maintains a sticky, acknowledgeable change flag.
// Define SW_COND_EDGE_EN to expose per-bit sw_rise/sw_fall pulses.
module switch_conditioner
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = SW_COND_DEF_WIDTH,
    parameter int SYNC_STAGES     = SW_COND_DEF_SYNC,
    parameter int DEBOUNCE_CYCLES = SW_COND_DEF_DEBOUNCE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             change_ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic             change_pending
`ifdef SW_COND_EDGE_EN
    ,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`endif
);

    logic [WIDTH-1:0] toggle;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clock  (clock),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i]),
            .toggle (toggle[i])
`ifdef SW_COND_EDGE_EN
            ,
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
`endif
        );
    end

    // A toggle on the same edge as an ack keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            change_pending <= 1'b0;
        end else if (|toggle) begin
            change_pending <= 1'b1;
        end else if (change_ack) begin
            change_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Edge-pulse checks are compiled in when SW_COND_EDGE_EN is defined.
module tb_switch_conditioner;

    localparam int WIDTH = 5;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sw_raw;
    logic             change_ack;
    logic [WIDTH-1:0] sw_stable;
    logic             change_pending;
`ifdef SW_COND_EDGE_EN
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    switch_conditioner #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sw_raw         (sw_raw),
        .change_ack     (change_ack),
        .sw_stable      (sw_stable),
        .change_pending (change_pending)
`ifdef SW_COND_EDGE_EN
        ,
        .sw_rise        (sw_rise),
        .sw_fall        (sw_fall)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference model: a level is accepted once the synchronised input has
    // disagreed with the accepted level for DEB consecutive edges.
    logic [WIDTH-1:0] m_pipe [SYNC];
    int               m_run  [WIDTH];
    logic [WIDTH-1:0] m_stable, m_rise, m_fall, m_sync;
    logic             m_pend, m_tog;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC; s++) m_pipe[s] = '0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_pend   = 1'b0;
        end else begin
            m_sync = m_pipe[SYNC-1];
            m_tog  = 1'b0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_sync[i] != m_stable[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_run[i]    = 0;
                    m_stable[i] = ~m_stable[i];
                    if (m_stable[i]) m_rise[i] = 1'b1;
                    else m_fall[i] = 1'b1;
                    m_tog = 1'b1;
                end
            end
            if (m_tog) m_pend = 1'b1;
            else if (change_ack) m_pend = 1'b0;
            for (int s = SYNC - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
            m_pipe[0] = sw_raw;
        end
    end

    always @(negedge clock) begin
        chk("model_stable", 32'(sw_stable), 32'(m_stable));
        chk("model_pending", 32'(change_pending), 32'(m_pend));
`ifdef SW_COND_EDGE_EN
        chk("model_rise", 32'(sw_rise), 32'(m_rise));
        chk("model_fall", 32'(sw_fall), 32'(m_fall));
`endif
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        sw_raw     = 5'b11111;
        change_ack = 1'b0;

        // Reset with all switches high, then release.
        step(3);
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_pending", 32'(change_pending), 32'h0);
`ifdef SW_COND_EDGE_EN
        chk("rst_rise", 32'(sw_rise), 32'h0);
`endif
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("rel_stable", 32'(sw_stable), (k == 6) ? 32'h1f : 32'h0);
        end
        chk("rel_pending", 32'(change_pending), 32'h1);
`ifdef SW_COND_EDGE_EN
        chk("rel_rise", 32'(sw_rise), 32'h1f);
        step(1);
        chk("rel_rise_done", 32'(sw_rise), 32'h0);
`endif

        // Return to 0 and acknowledge.
        sw_raw = '0;
        step(8);
        change_ack = 1'b1;
        step(1);
        change_ack = 1'b0;
        chk("zero_stable", 32'(sw_stable), 32'h0);
        chk("zero_pending", 32'(change_pending), 32'h0);

        // Glitch on bit 2 shorter than the debounce window.
        sw_raw[2] = 1'b1;
        step(3);
        sw_raw[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("glitch_stable", 32'(sw_stable), 32'h0);
            chk("glitch_pending", 32'(change_pending), 32'h0);
        end

        // Independent bits: bit 0 at cycle 0, bit 4 at cycle 2.
        sw_raw = 5'b00001;
        step(2);
        sw_raw = 5'b10001;
        for (int k = 3; k <= 8; k++) begin
            step(1);
            chk("indep_stable", 32'(sw_stable),
                (k < 6) ? 32'h00 : ((k < 8) ? 32'h01 : 32'h11));
            if (k == 6) chk("indep_pending", 32'(change_pending), 32'h1);
        end

        // Ack race with bit 1 falling.
        change_ack = 1'b1;
        step(1);
        change_ack = 1'b0;
        sw_raw = 5'b10011;
        step(6);
        chk("race_rise_stable", 32'(sw_stable), 32'h13);
        change_ack = 1'b1;
        step(1);
        change_ack = 1'b0;
        chk("race_pre_pending", 32'(change_pending), 32'h0);
        sw_raw = 5'b10001;
        step(5);
        change_ack = 1'b1;
        step(1);
        chk("race_stable", 32'(sw_stable), 32'h11);
        chk("race_pending_set_wins", 32'(change_pending), 32'h1);
`ifdef SW_COND_EDGE_EN
        chk("race_fall", 32'(sw_fall), 32'h02);
`endif
        step(1);
        change_ack = 1'b0;
        chk("race_pending_cleared", 32'(change_pending), 32'h0);

        // Asynchronous reset two cycles into a count.
        sw_raw = 5'b11001;
        step(4);
        #3 reset = 1'b0;
        #1;
        chk("async_stable", 32'(sw_stable), 32'h0);
        chk("async_pending", 32'(change_pending), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("requal_stable", 32'(sw_stable), (k == 6) ? 32'h19 : 32'h0);
        end

        // Randomised traffic, checked continuously against the model.
        for (int c = 0; c < 800; c++) begin
            step(1);
            if ($urandom_range(0, 4) == 0) begin
                int b;
                b = int'($urandom_range(0, WIDTH - 1));
                sw_raw[b] = ~sw_raw[b];
            end
            change_ack = ($urandom_range(0, 6) == 0);
        end
        change_ack = 1'b0;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
